packet_builder: RTL and testbench

Transmit-side counterpart of the stream packet parser. Accepts one payload of 1–37 bytes plus a stream ID, assigns the next per-stream sequence number, and serialises the packet onto a 32-bit valid/ready word stream: header word, sequence word, then payload words, with `dataOut_last` on the final word. The packet format and sequence numbering match what the parser checks, so a builder→parser loopback reports no packet loss.

---
 rtl/packet_builder.sv | 208 ++++++++++++++++++++
 tb/tb_packet_builder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_builder.sv
// packet_builder: serialises a 1..37 byte payload into header/seq/data words.
// Optional define SEQ_INJECT_EN adds a sequence-number override input.
`timescale 1ns/1ps
module packet_builder #(
  parameter int STREAM_BITS = 5
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [0:295] payload,
  input  logic [5:0]   payloadBytes,
  input  logic [15:0]  streamId,
  input  logic         payload_val,
  output logic         payload_ready,
`ifdef SEQ_INJECT_EN
  input  logic         seqOverride_en,
  input  logic [31:0]  seqOverride,
`endif
  output logic [31:0]  dataOut,
  output logic         dataOut_val,
  input  logic         dataOut_ready,
  output logic         dataOut_last,
  output logic         lenErr
);

  localparam int NENT = 1 << STREAM_BITS;
  localparam int NW   = 10;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_SEQ,
    SEND_DATA
  } state_t;

  state_t state;
  state_t state_n;

  logic [31:0] seq_tab [NENT];
  logic [31:0] pay_w [NW];
  logic [31:0] seq_q;
  logic [3:0]  nwords_q;
  logic [3:0]  widx_q;
  logic [3:0]  widx_n;

  logic [STREAM_BITS-1:0] idx;
  logic        legal;
  logic        cap;
  logic        take;
  logic [31:0] seq_new;
  logic [31:0] hdr;
  logic [3:0]  nwords_in;
  logic [0:319] pay_mask;
  logic        last_sel;

  logic [31:0] word_n;
  logic        val_n;
  logic        last_n;
  logic        err_n;

  assign idx   = streamId[STREAM_BITS-1:0];
  assign legal = (payloadBytes != 6'd0) && (payloadBytes <= 6'd37);
  assign cap   = payload_val && payload_ready;
  assign hdr   = {({10'd0, payloadBytes} + 16'd8), streamId};

  // Word count is ceil(bytes/4); at most 10 for a legal length.
  assign nwords_in = payloadBytes[5:2] + {3'b000, |payloadBytes[1:0]};

  assign last_sel = (widx_q == (nwords_q - 4'd1));

  // Next sequence number: table entry + 1, or the injected override.
  always_comb begin
    seq_new = seq_tab[idx] + 32'd1;
`ifdef SEQ_INJECT_EN
    if (seqOverride_en) begin
      seq_new = seqOverride;
    end
`endif
  end

  // Zero every byte past the payload length, and the padding past bit 295.
  always_comb begin
    pay_mask = '0;
    for (int k = 0; k < 37; k++) begin
      if (6'(k) < payloadBytes) begin
        pay_mask[8*k +: 8] = payload[8*k +: 8];
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    word_n  = dataOut;
    val_n   = dataOut_val;
    last_n  = dataOut_last;
    err_n   = 1'b0;
    widx_n  = widx_q;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cap) begin
          if (legal) begin
            take    = 1'b1;
            state_n = SEND_HDR;
            word_n  = hdr;
            val_n   = 1'b1;
            last_n  = 1'b0;
            widx_n  = 4'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SEND_HDR: begin
        if (dataOut_ready) begin
          state_n = SEND_SEQ;
          word_n  = seq_q;
        end
      end
      SEND_SEQ: begin
        if (dataOut_ready) begin
          state_n = SEND_DATA;
          word_n  = pay_w[widx_q];
          last_n  = last_sel;
          widx_n  = widx_q + 4'd1;
        end
      end
      SEND_DATA: begin
        if (dataOut_ready) begin
          if (dataOut_last) begin
            state_n = IDLE;
            word_n  = '0;
            val_n   = 1'b0;
            last_n  = 1'b0;
          end else begin
            word_n = pay_w[widx_q];
            last_n = last_sel;
            widx_n = widx_q + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        val_n   = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs; payload_ready mirrors the next state being IDLE.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dataOut       <= '0;
      dataOut_val   <= 1'b0;
      dataOut_last  <= 1'b0;
      lenErr        <= 1'b0;
      payload_ready <= 1'b1;
    end else begin
      dataOut       <= word_n;
      dataOut_val   <= val_n;
      dataOut_last  <= last_n;
      lenErr        <= err_n;
      payload_ready <= (state_n == IDLE);
    end
  end

  // Packet holding registers, loaded on a legal capture.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NW; i++) begin
        pay_w[i] <= '0;
      end
      seq_q    <= '0;
      nwords_q <= '0;
      widx_q   <= '0;
    end else begin
      widx_q <= widx_n;
      if (take) begin
        for (int i = 0; i < NW; i++) begin
          pay_w[i] <= pay_mask[32*i +: 32];
        end
        seq_q    <= seq_new;
        nwords_q <= nwords_in;
      end
    end
  end

  // Per-stream last-sent sequence numbers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NENT; i++) begin
        seq_tab[i] <= '0;
      end
    end else if (take) begin
      seq_tab[idx] <= seq_new;
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// tb_packet_builder: directed and random checks of packet_builder
// against a queue-based packet model.
`timescale 1ns/1ps
module tb_packet_builder;

  typedef struct {
    logic [31:0] w;
    logic        l;
    int          c;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic [0:295] payload = '0;
  logic [5:0]   payloadBytes = '0;
  logic [15:0]  streamId = '0;
  logic         payload_val = 1'b0;
  logic         payload_ready;
  logic         seq_ovr_en = 1'b0;
  logic [31:0]  seq_ovr = '0;
  logic [31:0]  dataOut;
  logic         dataOut_val;
  logic         dataOut_ready = 1'b1;
  logic         dataOut_last;
  logic         lenErr;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_len = 0;

  beat_t exp_q[$];
  beat_t acc[$];
  int unsigned tab [32];
  bit busy = 1'b0;
  bit exp_len = 1'b0;
  bit prev_val = 1'b0;
  bit prev_rdy = 1'b0;
  logic [31:0] prev_word = '0;
  logic prev_last = 1'b0;

  bit rnd_rdy = 1'b0;
  bit force_rdy = 1'b1;

  always #5 clk = ~clk;

  packet_builder dut (
    .clk(clk),
    .reset_b(reset_b),
    .payload(payload),
    .payloadBytes(payloadBytes),
    .streamId(streamId),
    .payload_val(payload_val),
    .payload_ready(payload_ready),
`ifdef SEQ_INJECT_EN
    .seqOverride_en(seq_ovr_en),
    .seqOverride(seq_ovr),
`endif
    .dataOut(dataOut),
    .dataOut_val(dataOut_val),
    .dataOut_ready(dataOut_ready),
    .dataOut_last(dataOut_last),
    .lenErr(lenErr)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Model: a capture becomes a list of beats built from the packet rules.
  task automatic model_capture();
    int n;
    int nw;
    logic [15:0] sid;
    logic [31:0] seq;
    logic [31:0] wd;
    logic [7:0]  by;
    beat_t b;
    n = int'(payloadBytes);
    sid = streamId;
    if (n == 0 || n > 37) begin
      exp_len = 1'b1;
    end else begin
      seq = tab[sid[4:0]] + 32'd1;
`ifdef SEQ_INJECT_EN
      if (seq_ovr_en) seq = seq_ovr;
`endif
      tab[sid[4:0]] = seq;
      b.c = 0;
      b.w = {16'(n + 8), sid};
      b.l = 1'b0;
      exp_q.push_back(b);
      b.w = seq;
      exp_q.push_back(b);
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        wd = '0;
        for (int j = 0; j < 4; j++) begin
          by = '0;
          if (4*w + j < n) by = payload[8*(4*w+j) +: 8];
          wd = {wd[23:0], by};
        end
        b.w = wd;
        b.l = (w == nw - 1);
        exp_q.push_back(b);
      end
      busy = 1'b1;
    end
  endtask

  // Compare process: checks outputs every cycle, then advances the model.
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (!reset_b) begin
      chk1("rst_val", dataOut_val, 1'b0);
      chk1("rst_last", dataOut_last, 1'b0);
      chk1("rst_lenerr", lenErr, 1'b0);
      chk1("rst_ready", payload_ready, 1'b1);
      chk("rst_data", dataOut, 32'd0);
      exp_q.delete();
      busy = 1'b0;
      exp_len = 1'b0;
      for (int i = 0; i < 32; i++) tab[i] = 0;
      prev_val = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      chk1("lenerr", lenErr, exp_len);
      if (lenErr) n_len++;
      exp_len = 1'b0;
      chk1("payload_ready", payload_ready, !busy);
      chk1("out_val", dataOut_val, busy);
      if (prev_val && !prev_rdy) begin
        chk1("hold_val", dataOut_val, 1'b1);
        chk("hold_word", dataOut, prev_word);
        chk1("hold_last", dataOut_last, prev_last);
      end
      if (dataOut_val) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got %h expected no beat", dataOut);
        end else begin
          chk("word", dataOut, exp_q[0].w);
          chk1("last", dataOut_last, exp_q[0].l);
        end
      end
      if (dataOut_val && dataOut_ready) begin
        b.w = dataOut;
        b.l = dataOut_last;
        b.c = cyc;
        acc.push_back(b);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          if (b.l) busy = 1'b0;
        end
      end
      prev_val = dataOut_val;
      prev_rdy = dataOut_ready;
      prev_word = dataOut;
      prev_last = dataOut_last;
      if (payload_val && payload_ready) model_capture();
    end
  end

  // Downstream ready: fixed or randomly throttled.
  always @(posedge clk) begin
    #1;
    dataOut_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  function automatic logic [0:295] rnd_pl();
    logic [0:295] v;
    for (int k = 0; k < 37; k++) v[8*k +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic send(input logic [15:0] sid, input int n,
                      input logic [0:295] pl, input bit oen,
                      input logic [31:0] ov);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    streamId = sid;
    payloadBytes = 6'(n);
    payload = pl;
    seq_ovr_en = oen;
    seq_ovr = ov;
    payload_val = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (payload_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    payload_val = 1'b0;
    seq_ovr_en = 1'b0;
    chk1("capture_in_time", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk1("idle_in_time", done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [0:295] pl;
    int n;
    bit hit;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // Full 37-byte packet on stream 3.
    acc.delete();
    send(16'h0003, 37, rnd_pl(), 1'b0, 32'd0);
    wait_idle();
    chk("t1_beats", 32'(acc.size()), 32'd12);
    chk("t1_hdr", acc[0].w, 32'h002D0003);
    chk("t1_seq", acc[1].w, 32'h00000001);
    chk1("t1_last", acc[11].l, 1'b1);
    chk1("t1_not_last", acc[10].l, 1'b0);
    chk("t1_pad", {8'd0, acc[11].w[23:0]}, 32'd0);
    chk("t1_span", 32'(acc[11].c - acc[0].c), 32'd11);

    // 5-byte packet with garbage beyond the length.
    acc.delete();
    pl = rnd_pl();
    pl[0:39] = 40'h1122334455;
    send(16'h0003, 5, pl, 1'b0, 32'd0);
    wait_idle();
    chk("t2_beats", 32'(acc.size()), 32'd4);
    chk("t2_hdr", acc[0].w, 32'h000D0003);
    chk("t2_seq", acc[1].w, 32'd2);
    chk("t2_w0", acc[2].w, 32'h11223344);
    chk("t2_w1", acc[3].w, 32'h55000000);
    chk1("t2_last", acc[3].l, 1'b1);

    // Aliased stream 0x23 with a stall on the sequence word.
    acc.delete();
    send(16'h0023, 5, pl, 1'b0, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (acc.size() >= 1) begin
        hit = 1'b1;
        break;
      end
    end
    chk1("t3_hdr_seen", hit, 1'b1);
    force_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    force_rdy = 1'b1;
    wait_idle();
    chk("t3_beats", 32'(acc.size()), 32'd4);
    chk("t3_hdr", acc[0].w, 32'h000D0023);
    chk("t3_seq", acc[1].w, 32'd3);
    chk("t3_stall", 32'(acc[1].c - acc[0].c), 32'd4);
    chk("t3_w1", acc[3].w, 32'h55000000);

    // Illegal lengths, back to back, then the next legal packet.
    acc.delete();
    n_len = 0;
    send(16'h0003, 0, pl, 1'b0, 32'd0);
    send(16'h0003, 38, pl, 1'b0, 32'd0);
    wait_idle();
    chk("t4_lenerr_pulses", 32'(n_len), 32'd2);
    chk("t4_no_beats", 32'(acc.size()), 32'd0);
    send(16'h0003, 4, pl, 1'b0, 32'd0);
    wait_idle();
    chk("t4_seq", acc[1].w, 32'd4);

`ifdef SEQ_INJECT_EN
    acc.delete();
    send(16'h0007, 4, pl, 1'b1, 32'hFFFFFFFF);
    wait_idle();
    chk("inj_seq", acc[1].w, 32'hFFFFFFFF);
    acc.delete();
    send(16'h0007, 4, pl, 1'b0, 32'd0);
    wait_idle();
    chk("inj_wrap", acc[1].w, 32'h00000000);
`endif

    // Random traffic with throttled ready and one mid-packet reset.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 250; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(38, 63));
      end else begin
        n = int'($urandom_range(1, 37));
      end
      send(16'($urandom_range(0, 63)), n, rnd_pl(),
           ($urandom_range(0, 7) == 0), $urandom);
      if (p == 120) begin
        repeat (3) @(posedge clk);
        #1;
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rnd_rdy = 1'b0;
    force_rdy = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
